// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and seconds constants for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam int          SEC_W   = 6;
    localparam logic [5:0]  SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - control bundle between the stopwatch controller and its counters
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic [SEC_W-1:0] seconds_value;
    logic             sec_en;
    logic             min_en;
    logic             cnt_dir;
    logic             counter_clr;

    modport master (
        input  seconds_value,
        output sec_en, min_en, cnt_dir, counter_clr
    );

    modport slave (
        output seconds_value,
        input  sec_en, min_en, cnt_dir, counter_clr
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and rising-edge pulse for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level_d    <= 1'b0;
            btn_level  <= 1'b0;
            btn_pulse  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            level_d   <= btn_level;
            btn_pulse <= btn_level & ~level_d;
            // Any bounce back to the accepted level restarts the stability window.
            if (sync2 == btn_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                btn_level  <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch RUN/PAUSED/ADJUST sequencer; STOPWATCH_BLINK_EN adds the adjust blink
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV_1HZ         = 100_000_000,
    parameter int DIV_2HZ         = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_pause,
    input  logic              btn_clr,
    input  logic              sel,
    input  logic              adj,
    input  logic              dir,
    stopwatch_ctrl_if.master  ctr,
    output logic              paused,
    output logic [1:0]        state,
    output logic              blink
);
    localparam int            PW       = $clog2(DIV_1HZ);
    localparam logic [PW-1:0] TERM_RUN = PW'(DIV_1HZ - 1);
    localparam logic [PW-1:0] TERM_ADJ = PW'(DIV_2HZ - 1);

    state_t        state_q, state_d, saved_q, saved_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          pause_pulse, clr_pulse, pause_level, clr_level;
    logic          tick, carry, sec_en_d, min_en_d;
    logic          unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk(clk), .reset(reset), .btn_raw(btn_pause),
        .btn_level(pause_level), .btn_pulse(pause_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk(clk), .reset(reset), .btn_raw(btn_clr),
        .btn_level(clr_level), .btn_pulse(clr_pulse)
    );

    assign unused_levels = pause_level ^ clr_level;
    assign state         = state_q;
    assign paused        = (state_q == PAUSED);

    // Out-of-range seconds never match either wrap point, so they never carry.
    assign carry = dir ? (ctr.seconds_value == '0) : (ctr.seconds_value == SEC_MAX);
    assign tick  = (state_q != PAUSED) &&
                   (pre_q == ((state_q == ADJUST) ? TERM_ADJ : TERM_RUN));

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        pre_d    = pre_q;
        sec_en_d = 1'b0;
        min_en_d = 1'b0;

        if (adj && state_q != ADJUST) begin
            state_d = ADJUST;
            saved_d = state_q;
        end else if (!adj && state_q == ADJUST) begin
            state_d = saved_q;
        end else if (pause_pulse && !clr_pulse) begin
            if (state_q == RUN)         state_d = PAUSED;
            else if (state_q == PAUSED) state_d = RUN;
        end

        if (state_d != state_q || clr_pulse) pre_d = '0;
        else if (state_q == PAUSED)          pre_d = pre_q;
        else if (tick)                       pre_d = '0;
        else                                 pre_d = pre_q + PW'(1);

        if (tick && !clr_pulse) begin
            if (state_q == RUN) begin
                sec_en_d = 1'b1;
                min_en_d = carry;
            end else if (state_q == ADJUST) begin
                sec_en_d = sel;
                min_en_d = ~sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            saved_q         <= RUN;
            pre_q           <= '0;
            ctr.sec_en      <= 1'b0;
            ctr.min_en      <= 1'b0;
            ctr.cnt_dir     <= 1'b0;
            ctr.counter_clr <= 1'b0;
        end else begin
            state_q         <= state_d;
            saved_q         <= saved_d;
            pre_q           <= pre_d;
            ctr.sec_en      <= sec_en_d;
            ctr.min_en      <= min_en_d;
            ctr.cnt_dir     <= dir;
            ctr.counter_clr <= clr_pulse;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    localparam int            BW        = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset || state_q != ADJUST) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_END) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end
`else
    localparam int unused_blink_div = BLINK_DIV;
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven and sequence checks for stopwatch_ctrl
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset, btn_pause, btn_clr, sel, adj, dir;
    logic       paused, blink;
    logic [1:0] state;

    stopwatch_ctrl_if ctr_if();

    stopwatch_ctrl #(
        .DIV_1HZ(10), .DIV_2HZ(5), .DEBOUNCE_CYCLES(4), .BLINK_DIV(3)
    ) dut (
        .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_clr(btn_clr),
        .sel(sel), .adj(adj), .dir(dir), .ctr(ctr_if),
        .paused(paused), .state(state), .blink(blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       adj;
        logic       sel;
        logic       dir;
        logic [5:0] sv;
        int         ncyc;
        int         exp_sec;
        int         exp_min;
        int         exp_both;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_pause = 1'b0; btn_clr = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // Holds the pause button for 8 cycles; reports the step at which target is reached and the first later sec_en.
    task automatic press_pause(input logic [1:0] target, output int t_state, output int t_sec);
        t_state = -1; t_sec = -1;
        for (int k = 1; k <= 30; k++) begin
            btn_pause = (k <= 8);
            step();
            if (t_state < 0 && state == target) t_state = k;
            else if (t_state >= 0 && t_sec < 0 && ctr_if.sec_en) t_sec = k;
        end
        btn_pause = 1'b0;
    endtask

    initial begin
        int n_sec, n_min, n_both, n_blink, n_clr, bad, t_a, t_b;
        logic prev_blink;

        //               adj   sel   dir   sv     ncyc sec min both state
        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'd10, 30, 3, 0, 0, 2'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 6'd59, 30, 3, 3, 3, 2'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 6'd0,  30, 3, 3, 3, 2'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 6'd59, 30, 3, 0, 0, 2'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 6'd0,  30, 3, 0, 0, 2'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 6'd63, 30, 3, 0, 0, 2'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 6'd10, 9,  0, 0, 0, 2'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 6'd59, 20, 3, 0, 0, 2'd2};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 6'd59, 20, 0, 3, 0, 2'd2};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 6'd0,  20, 0, 3, 0, 2'd2};

        sel = 1'b0; adj = 1'b1; dir = 1'b1; ctr_if.seconds_value = 6'd0;
        do_reset();
        check("reset_state", int'(state), 0);
        check("reset_sec_en", int'(ctr_if.sec_en), 0);
        check("reset_min_en", int'(ctr_if.min_en), 0);
        check("reset_counter_clr", int'(ctr_if.counter_clr), 0);
        check("reset_cnt_dir", int'(ctr_if.cnt_dir), 0);
        check("reset_paused", int'(paused), 0);
        check("reset_blink", int'(blink), 0);

        for (int v = 0; v < 10; v++) begin
            adj = 1'b0;
            do_reset();
            adj = vecs[v].adj; sel = vecs[v].sel; dir = vecs[v].dir;
            ctr_if.seconds_value = vecs[v].sv;
            n_sec = 0; n_min = 0; n_both = 0; n_blink = 0; prev_blink = blink;
            for (int k = 0; k < vecs[v].ncyc; k++) begin
                step();
                n_sec  += int'(ctr_if.sec_en);
                n_min  += int'(ctr_if.min_en);
                n_both += int'(ctr_if.sec_en & ctr_if.min_en);
`ifdef STOPWATCH_BLINK_EN
                if (blink != prev_blink) n_blink++;
                prev_blink = blink;
`else
                n_blink += int'(blink);
`endif
            end
            check($sformatf("vec%0d_sec_en", v), n_sec, vecs[v].exp_sec);
            check($sformatf("vec%0d_min_en", v), n_min, vecs[v].exp_min);
            check($sformatf("vec%0d_same_cycle", v), n_both, vecs[v].exp_both);
            check($sformatf("vec%0d_state", v), int'(state), int'(vecs[v].exp_state));
            check($sformatf("vec%0d_cnt_dir", v), int'(ctr_if.cnt_dir), int'(vecs[v].dir));
`ifdef STOPWATCH_BLINK_EN
            check($sformatf("vec%0d_blink_toggles", v), n_blink,
                  vecs[v].adj ? (vecs[v].ncyc - 1) / 3 : 0);
`else
            check($sformatf("vec%0d_blink_high", v), n_blink, 0);
`endif
        end

        // Short press is rejected, long press pauses, second press resumes.
        adj = 1'b0; sel = 1'b0; dir = 1'b0; ctr_if.seconds_value = 6'd10;
        do_reset();
        btn_pause = 1'b1;
        repeat (3) step();
        btn_pause = 1'b0;
        bad = 0;
        repeat (12) begin step(); if (state != RUN) bad++; end
        check("short_press_ignored", bad, 0);
        press_pause(PAUSED, t_a, t_b);
        check("pause_latency", t_a, 8);
        check("pause_no_sec_en", t_b, -1);
        check("paused_flag", int'(paused), 1);
        n_sec = 0;
        repeat (50) begin step(); n_sec += int'(ctr_if.sec_en | ctr_if.min_en); end
        check("paused_no_enables", n_sec, 0);
        press_pause(RUN, t_a, t_b);
        check("resume_latency", t_a, 8);
        check("resume_first_tick", t_b - t_a, 10);
        check("resume_paused_flag", int'(paused), 0);

        // Clear and pause pulses in the same cycle: clear wins.
        do_reset();
        repeat (5) step();
        n_clr = 0; bad = 0; t_a = -1; t_b = -1;
        for (int k = 1; k <= 30; k++) begin
            btn_pause = (k <= 8); btn_clr = (k <= 8);
            step();
            if (state != RUN) bad++;
            if (ctr_if.counter_clr) begin n_clr++; if (t_a < 0) t_a = k; end
            else if (t_a >= 0 && t_b < 0 && ctr_if.sec_en) t_b = k;
        end
        btn_pause = 1'b0; btn_clr = 1'b0;
        check("clr_pause_count", n_clr, 1);
        check("clr_pause_latency", t_a, 8);
        check("clr_pause_state_kept", bad, 0);
        check("clr_prescaler_restart", t_b - t_a, 10);

        // Clear pulse landing on a tick suppresses the enable.
        do_reset();
        repeat (2) step();
        t_a = 0;
        for (int k = 1; k <= 12; k++) begin
            btn_clr = (k <= 8);
            step();
            if (k == 8) begin
                check("clr_tick_counter_clr", int'(ctr_if.counter_clr), 1);
                check("clr_tick_sec_en_suppressed", int'(ctr_if.sec_en), 0);
            end
            t_a += int'(ctr_if.sec_en);
        end
        btn_clr = 1'b0;
        check("clr_tick_no_enables", t_a, 0);

        // ADJUST entered from PAUSED returns to PAUSED.
        do_reset();
        press_pause(PAUSED, t_a, t_b);
        check("adj_pre_paused", int'(state), 1);
        adj = 1'b1; sel = 1'b1;
        step();
        check("adj_enter_state", int'(state), 2);
        check("adj_paused_low", int'(paused), 0);
        n_sec = 0; n_min = 0;
        repeat (10) begin step(); n_sec += int'(ctr_if.sec_en); n_min += int'(ctr_if.min_en); end
        check("adj_sel1_sec", n_sec, 2);
        check("adj_sel1_min", n_min, 0);
        sel = 1'b0;
        n_sec = 0; n_min = 0;
        repeat (10) begin step(); n_sec += int'(ctr_if.sec_en); n_min += int'(ctr_if.min_en); end
        check("adj_sel0_sec", n_sec, 0);
        check("adj_sel0_min", n_min, 2);
        adj = 1'b0;
        step();
        check("adj_exit_state", int'(state), 1);
        check("adj_exit_paused", int'(paused), 1);
        check("adj_exit_blink", int'(blink), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
